// File: rtl/desc_mem_arb_pkg.sv
// Shared constants and types for the descriptor RAM arbiter.
package desc_mem_arb_pkg;
  localparam int ADDR_W = 10;
  localparam int DATA_W = 32;
  localparam int BE_W   = DATA_W / 8;

  typedef enum logic [1:0] {ARB = 2'd0, LOCK0 = 2'd1, LOCK1 = 2'd2} arb_state_e;
  typedef logic port_idx_t;
endpackage

// File: rtl/desc_mem_arbiter_if.sv
// Two Avalon-MM master ports plus the descriptor RAM port, bundled.
interface desc_mem_arbiter_if;
  import desc_mem_arb_pkg::*;

  logic [ADDR_W-1:0] m0_address,    m1_address;
  logic [BE_W-1:0]   m0_byteenable, m1_byteenable;
  logic              m0_read,       m1_read;
  logic              m0_write,      m1_write;
  logic [DATA_W-1:0] m0_writedata,  m1_writedata;
  logic              m0_lock,       m1_lock;
  logic              m0_waitrequest,   m1_waitrequest;
  logic [DATA_W-1:0] m0_readdata,      m1_readdata;
  logic              m0_readdatavalid, m1_readdatavalid;

  logic [ADDR_W-1:0] mem_address;
  logic [BE_W-1:0]   mem_byteenable;
  logic              mem_chipselect;
  logic              mem_write;
  logic [DATA_W-1:0] mem_writedata;
  logic              mem_clken;
  logic [DATA_W-1:0] mem_readdata;
  // sticky lock-timeout indication, observed by simulation only
  logic              lock_timeout;

  modport slave (
    input  m0_address, m0_byteenable, m0_read, m0_write, m0_writedata, m0_lock,
    input  m1_address, m1_byteenable, m1_read, m1_write, m1_writedata, m1_lock,
    output m0_waitrequest, m0_readdata, m0_readdatavalid,
    output m1_waitrequest, m1_readdata, m1_readdatavalid,
    output mem_address, mem_byteenable, mem_chipselect, mem_write, mem_writedata, mem_clken,
    input  mem_readdata,
    output lock_timeout
  );

  modport master (
    output m0_address, m0_byteenable, m0_read, m0_write, m0_writedata, m0_lock,
    output m1_address, m1_byteenable, m1_read, m1_write, m1_writedata, m1_lock,
    input  m0_waitrequest, m0_readdata, m0_readdatavalid,
    input  m1_waitrequest, m1_readdata, m1_readdatavalid,
    input  mem_address, mem_byteenable, mem_chipselect, mem_write, mem_writedata, mem_clken,
    output mem_readdata,
    input  lock_timeout
  );
endinterface

// File: rtl/rr_lock_arb2.sv
// Two-way round-robin grant with per-master lock and idle timeout on a held lock.
module rr_lock_arb2
  import desc_mem_arb_pkg::*;
#(
  parameter int LOCK_TIMEOUT = 16
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [1:0] i_req,
  input  logic [1:0] i_lock,
  output logic [1:0] o_gnt,
  output logic       o_lock_timeout
);
  localparam logic [1:0] S_ARB   = ARB;
  localparam logic [1:0] S_LOCK0 = LOCK0;
  localparam logic [1:0] S_LOCK1 = LOCK1;
  localparam logic [7:0] IDLE_MAX = 8'(LOCK_TIMEOUT - 1);

  logic [1:0] r_state;
  logic       r_last;
  logic [7:0] r_idle;
  logic       r_to;
  port_idx_t  w_own;

  assign w_own          = (r_state == S_LOCK1);
  assign o_lock_timeout = r_to;

  // on a tie the port that did not win last time gets the slot
  always_comb begin
    o_gnt = 2'b00;
    case (r_state)
      S_ARB: begin
        o_gnt[0] = i_req[0] & (~i_req[1] |  r_last);
        o_gnt[1] = i_req[1] & (~i_req[0] | ~r_last);
      end
      S_LOCK0: o_gnt[0] = i_req[0];
      S_LOCK1: o_gnt[1] = i_req[1];
      default: o_gnt = 2'b00;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_ARB;
      r_last  <= 1'b1;
      r_idle  <= '0;
      r_to    <= 1'b0;
    end else begin
      if (|o_gnt) r_last <= o_gnt[1];
      if (r_state == S_ARB) begin
        r_idle <= '0;
        if (o_gnt[0] & i_lock[0])      r_state <= S_LOCK0;
        else if (o_gnt[1] & i_lock[1]) r_state <= S_LOCK1;
      end else if (i_req[w_own]) begin
        r_idle <= '0;
        if (!i_lock[w_own]) r_state <= S_ARB;
      end else if (!i_lock[w_own] || r_idle == IDLE_MAX) begin
        // owner dropped the lock, or sat idle too long while holding it
        r_state <= S_ARB;
        r_idle  <= '0;
        if (i_lock[w_own]) r_to <= 1'b1;
      end else begin
        r_idle <= r_idle + 8'd1;
      end
    end
  end
endmodule

// File: rtl/desc_mem_arbiter.sv
// Shares the single-port descriptor RAM between host (port 0) and SG-DMA (port 1).
module desc_mem_arbiter
  import desc_mem_arb_pkg::*;
#(
  parameter int LOCK_TIMEOUT = 16
) (
  input logic               clk,
  input logic               reset_n,
  desc_mem_arbiter_if.slave bus
);
  logic [1:0] w_req;
  logic [1:0] w_lock;
  logic [1:0] w_gnt;
  logic [1:0] r_rd_pend;

  assign w_req  = {bus.m1_read | bus.m1_write, bus.m0_read | bus.m0_write};
  assign w_lock = {bus.m1_lock, bus.m0_lock};

  rr_lock_arb2 #(.LOCK_TIMEOUT(LOCK_TIMEOUT)) u_arb (
    .i_clk          (clk),
    .i_rst_n        (reset_n),
    .i_req          (w_req),
    .i_lock         (w_lock),
    .o_gnt          (w_gnt),
    .o_lock_timeout (bus.lock_timeout)
  );

  assign bus.m0_waitrequest = w_req[0] & ~w_gnt[0];
  assign bus.m1_waitrequest = w_req[1] & ~w_gnt[1];

  // port 0 drives the RAM bus whenever port 1 is not granted
  assign bus.mem_address    = w_gnt[1] ? bus.m1_address    : bus.m0_address;
  assign bus.mem_byteenable = w_gnt[1] ? bus.m1_byteenable : bus.m0_byteenable;
  assign bus.mem_writedata  = w_gnt[1] ? bus.m1_writedata  : bus.m0_writedata;
  assign bus.mem_write      = (w_gnt[0] & bus.m0_write) | (w_gnt[1] & bus.m1_write);
  assign bus.mem_chipselect = |w_gnt;
  assign bus.mem_clken      = 1'b1;

  // write wins on an illegal read+write, so it never produces read data
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rd_pend <= 2'b00;
    end else begin
      r_rd_pend[0] <= w_gnt[0] & bus.m0_read & ~bus.m0_write;
      r_rd_pend[1] <= w_gnt[1] & bus.m1_read & ~bus.m1_write;
    end
  end

  assign bus.m0_readdatavalid = r_rd_pend[0];
  assign bus.m1_readdatavalid = r_rd_pend[1];
  assign bus.m0_readdata      = bus.mem_readdata;
  assign bus.m1_readdata      = bus.mem_readdata;

  always @(posedge clk) begin
    if (reset_n) begin
      a_rw0: assert (!(bus.m0_read && bus.m0_write));
      a_rw1: assert (!(bus.m1_read && bus.m1_write));
    end
  end
endmodule

// File: tb/tb_desc_mem_arbiter.sv
// Scoreboarded bench for desc_mem_arbiter with a behavioural 1-cycle RAM.
module tb_desc_mem_arbiter;
  import desc_mem_arb_pkg::*;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  desc_mem_arbiter_if bus();
  desc_mem_arbiter #(.LOCK_TIMEOUT(16)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));

  logic [31:0] ram    [1024] = '{default: '0};
  logic [31:0] shadow [1024] = '{default: '0};
  logic [31:0] r_q = '0;
  logic [31:0] q0[$], q1[$];
  int n_chk = 0, n_err = 0, nv0 = 0, nv1 = 0;

  always @(posedge clk) begin
    if (bus.mem_chipselect && bus.mem_clken) begin
      if (bus.mem_write) begin
        for (int b = 0; b < 4; b++)
          if (bus.mem_byteenable[b]) ram[bus.mem_address][8*b +: 8] <= bus.mem_writedata[8*b +: 8];
      end else begin
        r_q <= ram[bus.mem_address];
      end
    end
  end
  assign bus.mem_readdata = r_q;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic wt(int p);
    return (p == 0) ? bus.m0_waitrequest : bus.m1_waitrequest;
  endfunction

  task automatic acc(int p, logic wr, logic [9:0] a, logic [3:0] be, logic [31:0] d);
    if (wr) begin
      for (int b = 0; b < 4; b++) if (be[b]) shadow[a][8*b +: 8] = d[8*b +: 8];
    end else if (p == 0) q0.push_back(shadow[a]);
    else q1.push_back(shadow[a]);
  endtask

  // read data is checked before new acceptances so the queue order holds
  task automatic mon();
    if (!reset_n) begin
      q0.delete(); q1.delete();
      return;
    end
    if (bus.m0_readdatavalid) begin
      nv0++;
      chk("m0_rdv_q", 32'(q0.size() != 0), 1);
      if (q0.size() != 0) chk("m0_rdata", bus.m0_readdata, q0.pop_front());
    end
    if (bus.m1_readdatavalid) begin
      nv1++;
      chk("m1_rdv_q", 32'(q1.size() != 0), 1);
      if (q1.size() != 0) chk("m1_rdata", bus.m1_readdata, q1.pop_front());
    end
    if ((bus.m0_read || bus.m0_write) && !bus.m0_waitrequest)
      acc(0, bus.m0_write, bus.m0_address, bus.m0_byteenable, bus.m0_writedata);
    if ((bus.m1_read || bus.m1_write) && !bus.m1_waitrequest)
      acc(1, bus.m1_write, bus.m1_address, bus.m1_byteenable, bus.m1_writedata);
  endtask

  task automatic smp(); @(negedge clk); mon(); endtask
  task automatic nxt(); @(posedge clk); #1; endtask
  task automatic idle_cyc(int n); repeat (n) begin smp(); nxt(); end endtask

  task automatic drv(int p, logic rd, logic wr, logic [9:0] a, logic [3:0] be, logic [31:0] d, logic lk);
    if (p == 0) begin
      bus.m0_read = rd; bus.m0_write = wr; bus.m0_address = a;
      bus.m0_byteenable = be; bus.m0_writedata = d; bus.m0_lock = lk;
    end else begin
      bus.m1_read = rd; bus.m1_write = wr; bus.m1_address = a;
      bus.m1_byteenable = be; bus.m1_writedata = d; bus.m1_lock = lk;
    end
  endtask

  task automatic idl(int p, logic lk); drv(p, 0, 0, '0, '0, '0, lk); endtask

  // one transfer, held under waitrequest with a bounded wait
  task automatic xfer(int p, logic wr, logic [9:0] a, logic [3:0] be, logic [31:0] d);
    drv(p, ~wr, wr, a, be, d, 1'b0);
    for (int i = 0; ; i++) begin
      smp();
      if (!wt(p)) break;
      if (i == 40) begin chk("xfer_tmo", 32'(wt(p)), 0); break; end
      nxt();
    end
    nxt();
    idl(p, 1'b0);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    idle_cyc(2);
    reset_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=%0d exp=0", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int v0, v1, cnt;
    logic [31:0] rmw;
    idl(0, 1'b0); idl(1, 1'b0);

    // reset state: tie goes to port 0, waitrequest only with a request
    drv(0, 1, 0, 10'd0, 4'hF, '0, 0); drv(1, 1, 0, 10'd0, 4'hF, '0, 0);
    smp();
    chk("rst_w0", 32'(bus.m0_waitrequest), 0);
    chk("rst_w1", 32'(bus.m1_waitrequest), 1);
    chk("rst_v", {bus.m0_readdatavalid, bus.m1_readdatavalid}, 0);
    chk("rst_to", 32'(bus.lock_timeout), 0);
    nxt();
    idl(0, 0); idl(1, 0);
    smp();
    chk("rst_idle_w", {bus.m0_waitrequest, bus.m1_waitrequest}, 0);
    nxt();
    reset_n = 1'b1;

    xfer(0, 1, 10'd1, 4'hF, 32'h1111_0001);
    xfer(0, 1, 10'd2, 4'hF, 32'h2222_0002);
    xfer(0, 1, 10'd7, 4'hF, 32'h0000_0100);
    idle_cyc(2);

    // simple write then read on port 0
    do_reset();
    v0 = nv0; v1 = nv1;
    drv(0, 0, 1, 10'd5, 4'hF, 32'hDEADBEEF, 0);
    smp(); chk("t1_wr_w", 32'(bus.m0_waitrequest), 0); nxt();
    drv(0, 1, 0, 10'd5, 4'hF, '0, 0);
    smp(); chk("t1_rd_w", 32'(bus.m0_waitrequest), 0); nxt();
    idl(0, 0);
    smp();
    chk("t1_rdv", 32'(bus.m0_readdatavalid), 1);
    chk("t1_rdata", bus.m0_readdata, 32'hDEADBEEF);
    nxt();
    idle_cyc(2);
    chk("t1_nv0", 32'(nv0 - v0), 1);
    chk("t1_nv1", 32'(nv1 - v1), 0);

    // both ports read every cycle: strict alternation starting with port 0
    do_reset();
    v0 = nv0; v1 = nv1;
    drv(0, 1, 0, 10'd1, 4'hF, '0, 0); drv(1, 1, 0, 10'd2, 4'hF, '0, 0);
    for (int k = 0; k < 8; k++) begin
      smp();
      chk("t2_w0", 32'(bus.m0_waitrequest), 32'(k % 2));
      chk("t2_w1", 32'(bus.m1_waitrequest), 32'(1 - k % 2));
      nxt();
    end
    idl(0, 0); idl(1, 0);
    idle_cyc(3);
    chk("t2_nv0", 32'(nv0 - v0), 4);
    chk("t2_nv1", 32'(nv1 - v1), 4);

    // locked read-modify-write on port 1 against a streaming port-0 writer
    do_reset();
    drv(1, 1, 0, 10'd7, 4'hF, '0, 1);
    smp(); chk("t3_rd_w1", 32'(bus.m1_waitrequest), 0); nxt();
    idl(1, 1);
    drv(0, 0, 1, 10'd7, 4'hF, 32'hA5A5_A5A5, 0);
    smp(); rmw = bus.m1_readdata; chk("t3_w0_a", 32'(bus.m0_waitrequest), 1); nxt();
    drv(1, 0, 1, 10'd7, 4'hF, rmw + 32'd1, 0);
    smp();
    chk("t3_w0_b", 32'(bus.m0_waitrequest), 1);
    chk("t3_w1", 32'(bus.m1_waitrequest), 0);
    nxt();
    idl(1, 0);
    smp();
    chk("t3_ram_m1", ram[7], 32'h0000_0101);
    chk("t3_w0_c", 32'(bus.m0_waitrequest), 0);
    nxt();
    idl(0, 0);
    smp(); chk("t3_ram_m0", ram[7], 32'hA5A5_A5A5); nxt();
    xfer(1, 0, 10'd7, 4'hF, '0);
    idle_cyc(2);

    // port 0 holds an idle lock; port 1 waits out the timeout
    do_reset();
    chk("t4_to0", 32'(bus.lock_timeout), 0);
    drv(0, 1, 0, 10'd3, 4'hF, '0, 1);
    smp(); chk("t4_w0", 32'(bus.m0_waitrequest), 0); nxt();
    idl(0, 1);
    drv(1, 1, 0, 10'd4, 4'hF, '0, 0);
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      smp();
      if (!bus.m1_waitrequest) break;
      cnt++;
      nxt();
    end
    chk("t4_stall", 32'(cnt), 16);
    chk("t4_to", 32'(bus.lock_timeout), 1);
    nxt();
    idl(1, 0); idl(0, 0);
    idle_cyc(2);

    // byte-enable merge at the top word, plus address 0
    xfer(0, 1, 10'd1023, 4'hF, 32'h1122_3344);
    xfer(0, 1, 10'd1023, 4'b0010, 32'h0000_AB00);
    xfer(0, 0, 10'd1023, 4'hF, '0);
    smp(); chk("t5_rdata", bus.m0_readdata, 32'h1122_AB44); nxt();
    xfer(1, 1, 10'd0, 4'hF, 32'h0BAD_F00D);
    xfer(1, 0, 10'd0, 4'hF, '0);
    idle_cyc(2);

    // reset lands while a port-1 read is in flight
    do_reset();
    drv(1, 1, 0, 10'd2, 4'hF, '0, 0);
    smp(); chk("t6_w1", 32'(bus.m1_waitrequest), 0); nxt();
    reset_n = 1'b0;
    idl(1, 0);
    smp(); chk("t6_rdv_rst", 32'(bus.m1_readdatavalid), 0); nxt();
    idle_cyc(1);
    reset_n = 1'b1;
    smp(); chk("t6_rdv_post", 32'(bus.m1_readdatavalid), 0); nxt();
    drv(0, 1, 0, 10'd5, 4'hF, '0, 0);
    smp(); chk("t6_w0", 32'(bus.m0_waitrequest), 0); nxt();
    idl(0, 0);
    idle_cyc(3);

    chk("q_empty", 32'(q0.size() + q1.size()), 0);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
